// File: rtl/cache_axi_arbiter.sv
// Serialises instruction-cache refills and data-cache reads/writes onto one single-beat
// AXI3 master port. The fixed burst attributes (len=0, size=4B, INCR, wlast=1) are tied off outside this block.
module cache_axi_arbiter #(
    localparam int unsigned ADDR_W = 32,
    localparam int unsigned DATA_W = 32,
    localparam int unsigned ID_W   = 4,
    localparam int unsigned STRB_W = 4,
    parameter logic [ID_W-1:0] INST_ID = 4'd0,
    parameter logic [ID_W-1:0] DATA_ID = 4'd1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_cache_req,
    input  logic [ADDR_W-1:0] inst_cache_addr,
    output logic [DATA_W-1:0] inst_cache_rdata,
    output logic              inst_cache_dok,
    input  logic              data_cache_req,
    input  logic              data_cache_wr,
    input  logic [STRB_W-1:0] data_cache_wstrb,
    input  logic [ADDR_W-1:0] data_cache_addr,
    input  logic [DATA_W-1:0] data_cache_wdata,
    output logic [DATA_W-1:0] data_cache_rdata,
    output logic              data_cache_dok,
    output logic [ID_W-1:0]   arid,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [ID_W-1:0]   rid,
    input  logic [DATA_W-1:0] rdata,
    input  logic              rvalid,
    output logic              rready,
    output logic [ID_W-1:0]   awid,
    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic [STRB_W-1:0] wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic              bvalid,
    output logic              bready
);

    typedef enum logic [2:0] {IDLE, AR, R, AW_W, B, DONE} state_t;

    state_t state;
    logic   owner_data;
    logic   aw_done;
    logic   w_done;
    logic   aw_hs_c;
    logic   w_hs_c;
    logic   rid_unused;

    assign aw_hs_c    = awvalid & awready;
    assign w_hs_c     = wvalid & wready;
    assign awid       = DATA_ID;
    // Only one transaction is ever outstanding, so the returned id carries no information.
    assign rid_unused = ^rid;

    // Request arbitration, AXI channel sequencing and done-pulse generation.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state            <= IDLE;
            owner_data       <= 1'b0;
            aw_done          <= 1'b0;
            w_done           <= 1'b0;
            inst_cache_rdata <= '0;
            data_cache_rdata <= '0;
            inst_cache_dok   <= 1'b0;
            data_cache_dok   <= 1'b0;
            arid             <= '0;
            araddr           <= '0;
            arvalid          <= 1'b0;
            rready           <= 1'b0;
            awaddr           <= '0;
            awvalid          <= 1'b0;
            wdata            <= '0;
            wstrb            <= '0;
            wvalid           <= 1'b0;
            bready           <= 1'b0;
        end else begin
            inst_cache_dok <= 1'b0;
            data_cache_dok <= 1'b0;
            case (state)
                IDLE: begin
                    // The data request belongs to the older instruction, so it wins.
                    if (data_cache_req) begin
                        owner_data <= 1'b1;
                        if (data_cache_wr) begin
                            awaddr  <= data_cache_addr;
                            wdata   <= data_cache_wdata;
                            wstrb   <= data_cache_wstrb;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            aw_done <= 1'b0;
                            w_done  <= 1'b0;
                            state   <= AW_W;
                        end else begin
                            araddr  <= data_cache_addr;
                            arid    <= DATA_ID;
                            arvalid <= 1'b1;
                            state   <= AR;
                        end
                    end else if (inst_cache_req) begin
                        owner_data <= 1'b0;
                        araddr     <= inst_cache_addr;
                        arid       <= INST_ID;
                        arvalid    <= 1'b1;
                        state      <= AR;
                    end
                end
                AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= R;
                    end
                end
                R: begin
                    if (rvalid) begin
                        rready <= 1'b0;
                        if (owner_data) begin
                            data_cache_rdata <= rdata;
                            data_cache_dok   <= 1'b1;
                        end else begin
                            inst_cache_rdata <= rdata;
                            inst_cache_dok   <= 1'b1;
                        end
                        state <= DONE;
                    end
                end
                AW_W: begin
                    // Address and data channels complete independently, in any order.
                    if (aw_hs_c) begin
                        awvalid <= 1'b0;
                        aw_done <= 1'b1;
                    end
                    if (w_hs_c) begin
                        wvalid <= 1'b0;
                        w_done <= 1'b1;
                    end
                    if ((aw_done | aw_hs_c) && (w_done | w_hs_c)) begin
                        bready <= 1'b1;
                        state  <= B;
                    end
                end
                B: begin
                    if (bvalid) begin
                        bready         <= 1'b0;
                        data_cache_dok <= owner_data;
                        inst_cache_dok <= ~owner_data;
                        state          <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Randomised bench for cache_axi_arbiter: an AXI slave model with configurable latencies
// logs every handshake, and per-scenario tasks compare logs and done pulses with expected values.
module tb_cache_axi_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_cache_req;
    logic [31:0] inst_cache_addr;
    logic [31:0] inst_cache_rdata;
    logic        inst_cache_dok;
    logic        data_cache_req;
    logic        data_cache_wr;
    logic [3:0]  data_cache_wstrb;
    logic [31:0] data_cache_addr;
    logic [31:0] data_cache_wdata;
    logic [31:0] data_cache_rdata;
    logic        data_cache_dok;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic        bready;

    cache_axi_arbiter dut (
        .clk(clk), .resetn(resetn),
        .inst_cache_req(inst_cache_req), .inst_cache_addr(inst_cache_addr),
        .inst_cache_rdata(inst_cache_rdata), .inst_cache_dok(inst_cache_dok),
        .data_cache_req(data_cache_req), .data_cache_wr(data_cache_wr),
        .data_cache_wstrb(data_cache_wstrb), .data_cache_addr(data_cache_addr),
        .data_cache_wdata(data_cache_wdata), .data_cache_rdata(data_cache_rdata),
        .data_cache_dok(data_cache_dok),
        .arid(arid), .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Slave latency configuration (cycles of ready/valid delay).
    int ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
    bit          r_force = 1'b0;
    logic [31:0] r_force_val = '0;

    // Handshake logs written by the slave model.
    logic [31:0] ar_addr_log[$];
    logic [3:0]  ar_id_log[$];
    int          ar_hi_log[$];
    logic [31:0] r_data_log[$];
    logic [31:0] aw_addr_log[$];
    logic [3:0]  aw_id_log[$];
    int          aw_hi_log[$];
    logic [31:0] w_data_log[$];
    logic [3:0]  w_strb_log[$];
    int          w_hi_log[$];
    int          proto_err = 0;
    int          dok_err = 0;

    int          ar_wait, aw_wait, w_wait, r_cnt, b_cnt;
    bit          r_pend, b_pend, aw_got, w_got, txn_open, prev_idok, prev_ddok;
    logic [31:0] r_val, ar_hold, aw_hold, wd_hold;
    logic [3:0]  r_id, arid_hold, ws_hold;

    // AXI slave model: decides ready/valid at the falling edge for the next rising edge.
    initial begin
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rid = '0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        ar_wait = 0; aw_wait = 0; w_wait = 0; r_cnt = 0; b_cnt = 0;
        r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0; txn_open = 0;
        prev_idok = 0; prev_ddok = 0;
        r_val = '0; r_id = '0; ar_hold = '0; aw_hold = '0; wd_hold = '0; arid_hold = '0; ws_hold = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
                ar_wait = 0; aw_wait = 0; w_wait = 0; r_pend = 0; b_pend = 0;
                aw_got = 0; w_got = 0; txn_open = 0; prev_idok = 0; prev_ddok = 0;
            end else begin
                if (inst_cache_dok && data_cache_dok) dok_err++;
                if ((inst_cache_dok && prev_idok) || (data_cache_dok && prev_ddok)) dok_err++;
                if (inst_cache_dok || data_cache_dok) txn_open = 0;
                prev_idok = inst_cache_dok;
                prev_ddok = data_cache_dok;

                if (rready && !r_pend) proto_err++;
                rvalid = 1'b0;
                if (r_pend) begin
                    if (r_cnt > 0) r_cnt--;
                    else begin
                        rvalid = 1'b1; rdata = r_val; rid = r_id;
                        if (rready) begin r_data_log.push_back(r_val); r_pend = 0; end
                    end
                end
                if (arvalid) begin
                    if (ar_wait > 0 && (araddr !== ar_hold || arid !== arid_hold)) proto_err++;
                    ar_hold = araddr; arid_hold = arid;
                    arready = (ar_wait >= ar_delay);
                    if (arready) begin
                        ar_addr_log.push_back(araddr); ar_id_log.push_back(arid);
                        ar_hi_log.push_back(ar_wait + 1);
                        if (txn_open) proto_err++;
                        txn_open = 1; r_pend = 1; r_cnt = r_delay; r_id = arid;
                        r_val = r_force ? r_force_val : 32'($urandom());
                        ar_wait = 0;
                    end else ar_wait++;
                end else begin
                    if (ar_wait > 0) proto_err++;
                    ar_wait = 0; arready = 1'b0;
                end

                if (bready && !b_pend) proto_err++;
                bvalid = 1'b0;
                if (b_pend) begin
                    if (b_cnt > 0) b_cnt--;
                    else begin
                        bvalid = 1'b1;
                        if (bready) b_pend = 0;
                    end
                end
                if (awvalid) begin
                    if (aw_wait > 0 && awaddr !== aw_hold) proto_err++;
                    aw_hold = awaddr;
                    awready = (aw_wait >= aw_delay);
                    if (awready) begin
                        aw_addr_log.push_back(awaddr); aw_id_log.push_back(awid);
                        aw_hi_log.push_back(aw_wait + 1);
                        if (aw_got || (txn_open && !w_got)) proto_err++;
                        aw_got = 1; txn_open = 1; aw_wait = 0;
                    end else aw_wait++;
                end else begin
                    if (aw_wait > 0) proto_err++;
                    aw_wait = 0; awready = 1'b0;
                end
                if (wvalid) begin
                    if (w_wait > 0 && (wdata !== wd_hold || wstrb !== ws_hold)) proto_err++;
                    wd_hold = wdata; ws_hold = wstrb;
                    wready = (w_wait >= w_delay);
                    if (wready) begin
                        w_data_log.push_back(wdata); w_strb_log.push_back(wstrb);
                        w_hi_log.push_back(w_wait + 1);
                        if (w_got || (txn_open && !aw_got)) proto_err++;
                        w_got = 1; txn_open = 1; w_wait = 0;
                    end else w_wait++;
                end else begin
                    if (w_wait > 0) proto_err++;
                    w_wait = 0; wready = 1'b0;
                end
                if (aw_got && w_got) begin
                    b_pend = 1; b_cnt = b_delay; aw_got = 0; w_got = 0;
                end
            end
        end
    end

    task automatic start_req(input bit do_inst, input logic [31:0] ia, input bit do_data,
                             input bit wr, input logic [31:0] da, input logic [31:0] wd,
                             input logic [3:0] st);
        @(negedge clk);
        if (do_inst) begin inst_cache_req = 1'b1; inst_cache_addr = ia; end
        if (do_data) begin
            data_cache_req = 1'b1; data_cache_wr = wr; data_cache_addr = da;
            data_cache_wdata = wd; data_cache_wstrb = st;
        end
    endtask

    // Waits for the next done pulse; n is the number of falling edges waited, -1 on timeout.
    task automatic wait_dok(output int n, output bit was_data, output logic [31:0] rd);
        n = -1; was_data = 1'b0; rd = '0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (inst_cache_dok || data_cache_dok) begin
                n = i; was_data = data_cache_dok;
                rd = data_cache_dok ? data_cache_rdata : inst_cache_rdata;
                if (data_cache_dok) data_cache_req = 1'b0;
                if (inst_cache_dok) inst_cache_req = 1'b0;
                break;
            end
        end
    endtask

    task automatic set_delays(input int a, input int r, input int aw, input int w, input int b);
        ar_delay = a; r_delay = r; aw_delay = aw; w_delay = w; b_delay = b;
    endtask

    task automatic test_reset();
        tests_run++;
        if ({arvalid, rready, awvalid, wvalid, bready, inst_cache_dok, data_cache_dok} !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {arvalid, rready, awvalid, wvalid, bready, inst_cache_dok, data_cache_dok});
        end
        tests_run++;
        if ({araddr, awaddr, wdata, wstrb, arid, inst_cache_rdata, data_cache_rdata} !== '0) begin
            tests_failed++;
            $display("FAIL reset_data: araddr=%h awaddr=%h wdata=%h wstrb=%h arid=%h irdata=%h drdata=%h expected all 0",
                     araddr, awaddr, wdata, wstrb, arid, inst_cache_rdata, data_cache_rdata);
        end
        tests_run++;
        if (awid !== 4'd1) begin tests_failed++; $display("FAIL reset_awid: got %h expected 1", awid); end
    endtask

    task automatic test_inst_read();
        int n; bit wd_f; logic [31:0] rd; int ar0;
        set_delays(0, 0, 0, 0, 0);
        r_force = 1'b1; r_force_val = 32'h3C1DA000;
        ar0 = ar_addr_log.size();
        start_req(1'b1, 32'hBFC00010, 1'b0, 1'b0, '0, '0, '0);
        wait_dok(n, wd_f, rd);
        r_force = 1'b0;
        tests_run++;
        if (n !== 3) begin tests_failed++; $display("FAIL inst_latency: got %0d expected 3", n); end
        tests_run++;
        if (wd_f !== 1'b0 || rd !== 32'h3C1DA000) begin
            tests_failed++; $display("FAIL inst_dok: got data_owner=%0b rdata=%h expected 0 3c1da000", wd_f, rd);
        end
        tests_run++;
        if (ar_addr_log[ar0] !== 32'hBFC00010 || ar_id_log[ar0] !== 4'd0) begin
            tests_failed++; $display("FAIL inst_ar: got addr=%h id=%h expected bfc00010 0", ar_addr_log[ar0], ar_id_log[ar0]);
        end
        repeat (6) @(negedge clk);
        tests_run++;
        if (ar_addr_log.size() !== ar0 + 1 || inst_cache_rdata !== 32'h3C1DA000) begin
            tests_failed++;
            $display("FAIL inst_single: got ar_count=%0d rdata=%h expected %0d 3c1da000",
                     ar_addr_log.size() - ar0, inst_cache_rdata, 1);
        end
    endtask

    task automatic test_simultaneous();
        int n1, n2; bit d1, d2; logic [31:0] rd1, rd2; int ar0, rl0;
        set_delays(0, 0, 0, 0, 0);
        ar0 = ar_addr_log.size(); rl0 = r_data_log.size();
        start_req(1'b1, 32'hBFC00100, 1'b1, 1'b0, 32'h80001000, '0, '0);
        wait_dok(n1, d1, rd1);
        wait_dok(n2, d2, rd2);
        tests_run++;
        if (n1 !== 3 || d1 !== 1'b1) begin
            tests_failed++; $display("FAIL simul_first: got lat=%0d data_owner=%0b expected 3 1", n1, d1);
        end
        tests_run++;
        if (n2 !== 4 || d2 !== 1'b0) begin
            tests_failed++; $display("FAIL simul_second: got lat=%0d data_owner=%0b expected 4 0", n2, d2);
        end
        tests_run++;
        if (ar_addr_log[ar0] !== 32'h80001000 || ar_id_log[ar0] !== 4'd1 ||
            ar_addr_log[ar0+1] !== 32'hBFC00100 || ar_id_log[ar0+1] !== 4'd0) begin
            tests_failed++;
            $display("FAIL simul_ar_order: got %h/%h then %h/%h expected 80001000/1 then bfc00100/0",
                     ar_addr_log[ar0], ar_id_log[ar0], ar_addr_log[ar0+1], ar_id_log[ar0+1]);
        end
        tests_run++;
        if (rd1 !== r_data_log[rl0] || rd2 !== r_data_log[rl0+1]) begin
            tests_failed++;
            $display("FAIL simul_rdata: got %h %h expected %h %h", rd1, rd2, r_data_log[rl0], r_data_log[rl0+1]);
        end
    endtask

    task automatic test_write(input string tag, input int awd, input int wd, input int bd);
        int n, exp_n; bit wd_f; logic [31:0] rd; int aw0, w0, ar0;
        set_delays(0, 0, awd, wd, bd);
        aw0 = aw_addr_log.size(); w0 = w_data_log.size(); ar0 = ar_addr_log.size();
        exp_n = 3 + ((awd > wd) ? awd : wd) + bd;
        start_req(1'b0, '0, 1'b1, 1'b1, 32'h80002004, 32'hDEADBEEF, 4'b0011);
        wait_dok(n, wd_f, rd);
        repeat (3) @(negedge clk);
        tests_run++;
        if (n !== exp_n || wd_f !== 1'b1) begin
            tests_failed++; $display("FAIL %s_latency: got lat=%0d data_owner=%0b expected %0d 1", tag, n, wd_f, exp_n);
        end
        tests_run++;
        if (aw_addr_log.size() !== aw0 + 1 || w_data_log.size() !== w0 + 1 || ar_addr_log.size() !== ar0) begin
            tests_failed++;
            $display("FAIL %s_counts: got aw=%0d w=%0d ar=%0d expected 1 1 0", tag,
                     aw_addr_log.size() - aw0, w_data_log.size() - w0, ar_addr_log.size() - ar0);
        end
        tests_run++;
        if (aw_addr_log[aw0] !== 32'h80002004 || aw_id_log[aw0] !== 4'd1 ||
            w_data_log[w0] !== 32'hDEADBEEF || w_strb_log[w0] !== 4'b0011) begin
            tests_failed++;
            $display("FAIL %s_payload: got addr=%h id=%h data=%h strb=%b expected 80002004 1 deadbeef 0011", tag,
                     aw_addr_log[aw0], aw_id_log[aw0], w_data_log[w0], w_strb_log[w0]);
        end
        tests_run++;
        if (aw_hi_log[aw0] !== awd + 1 || w_hi_log[w0] !== wd + 1) begin
            tests_failed++;
            $display("FAIL %s_valid_len: got aw=%0d w=%0d expected %0d %0d", tag,
                     aw_hi_log[aw0], w_hi_log[w0], awd + 1, wd + 1);
        end
    endtask

    task automatic test_backpressure();
        int n; bit wd_f; logic [31:0] rd; int ar0, rl0;
        set_delays(5, 7, 0, 0, 0);
        ar0 = ar_addr_log.size(); rl0 = r_data_log.size();
        start_req(1'b0, '0, 1'b1, 1'b0, 32'h80003008, '0, '0);
        wait_dok(n, wd_f, rd);
        tests_run++;
        if (n !== 15 || wd_f !== 1'b1 || rd !== r_data_log[rl0]) begin
            tests_failed++;
            $display("FAIL bp_dok: got lat=%0d owner=%0b rdata=%h expected 15 1 %h", n, wd_f, rd, r_data_log[rl0]);
        end
        tests_run++;
        if (ar_hi_log[ar0] !== 6 || ar_addr_log[ar0] !== 32'h80003008) begin
            tests_failed++;
            $display("FAIL bp_ar: got valid_len=%0d addr=%h expected 6 80003008", ar_hi_log[ar0], ar_addr_log[ar0]);
        end
    endtask

    task automatic test_reset_midop();
        int n, doks, ar0, rl0; bit wd_f, seen; logic [31:0] rd;
        set_delays(0, 20, 0, 0, 0);
        seen = 1'b0;
        start_req(1'b1, 32'hBFC00200, 1'b0, 1'b0, '0, '0, '0);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rready) begin seen = 1'b1; break; end
        end
        tests_run++;
        if (seen !== 1'b1) begin tests_failed++; $display("FAIL rst_reach_r: got %0b expected 1", seen); end
        resetn = 1'b0;
        #1;
        tests_run++;
        if ({arvalid, rready, awvalid, wvalid, bready, inst_cache_dok, data_cache_dok} !== 7'b0 ||
            araddr !== '0 || inst_cache_rdata !== '0) begin
            tests_failed++;
            $display("FAIL rst_midop: got ctrl=%b araddr=%h irdata=%h expected 0 0 0",
                     {arvalid, rready, awvalid, wvalid, bready, inst_cache_dok, data_cache_dok}, araddr, inst_cache_rdata);
        end
        inst_cache_req = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        set_delays(0, 0, 0, 0, 0);
        ar0 = ar_addr_log.size();
        doks = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (inst_cache_dok || data_cache_dok) doks++;
        end
        tests_run++;
        if (doks !== 0 || ar_addr_log.size() !== ar0) begin
            tests_failed++; $display("FAIL rst_no_dok: got doks=%0d ars=%0d expected 0 0", doks, ar_addr_log.size() - ar0);
        end
        rl0 = r_data_log.size();
        start_req(1'b1, 32'hBFC00204, 1'b0, 1'b0, '0, '0, '0);
        wait_dok(n, wd_f, rd);
        tests_run++;
        if (n !== 3 || wd_f !== 1'b0 || rd !== r_data_log[rl0] || ar_addr_log[ar0] !== 32'hBFC00204) begin
            tests_failed++;
            $display("FAIL rst_recover: got lat=%0d owner=%0b rdata=%h addr=%h expected 3 0 %h bfc00204",
                     n, wd_f, rd, ar_addr_log[ar0], r_data_log[rl0]);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 24; t++) begin
            int mode, n, lr, lw, ar0, aw0, w0, rl0, iai, iri;
            bit d_wr, do_inst, do_data, wd_f;
            logic [31:0] ia, da, wd, rd;
            logic [3:0] st;
            mode = int'($urandom_range(0, 3));
            set_delays(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            ia = 32'($urandom()) & 32'hFFFF_FFFC;
            da = 32'($urandom());
            wd = 32'($urandom());
            st = 4'($urandom_range(1, 15));
            do_inst = (mode == 0) || (mode == 3);
            do_data = (mode != 0);
            d_wr = (mode == 2) || ((mode == 3) && ($urandom_range(0, 1) == 1));
            lr = 3 + ar_delay + r_delay;
            lw = 3 + ((aw_delay > w_delay) ? aw_delay : w_delay) + b_delay;
            ar0 = ar_addr_log.size(); aw0 = aw_addr_log.size(); w0 = w_data_log.size(); rl0 = r_data_log.size();
            start_req(do_inst, ia, do_data, d_wr, da, wd, st);
            if (do_data) begin
                wait_dok(n, wd_f, rd);
                tests_run++;
                if (n !== (d_wr ? lw : lr) || wd_f !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL rnd%0d_data_dok: got lat=%0d owner=%0b expected %0d 1", t, n, wd_f, d_wr ? lw : lr);
                end
                tests_run++;
                if (d_wr ? (aw_addr_log[aw0] !== da || w_data_log[w0] !== wd || w_strb_log[w0] !== st)
                         : (ar_addr_log[ar0] !== da || ar_id_log[ar0] !== 4'd1 || rd !== r_data_log[rl0])) begin
                    tests_failed++;
                    $display("FAIL rnd%0d_data_payload: got aw=%h w=%h/%b ar=%h/%h rd=%h expected addr=%h wdata=%h/%b",
                             t, aw_addr_log[aw0], w_data_log[w0], w_strb_log[w0], ar_addr_log[ar0], ar_id_log[ar0],
                             rd, da, wd, st);
                end
            end
            if (do_inst) begin
                iai = ar0 + ((do_data && !d_wr) ? 1 : 0);
                iri = rl0 + ((do_data && !d_wr) ? 1 : 0);
                wait_dok(n, wd_f, rd);
                tests_run++;
                if (n !== (do_data ? lr + 1 : lr) || wd_f !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL rnd%0d_inst_dok: got lat=%0d owner=%0b expected %0d 0", t, n, wd_f, do_data ? lr + 1 : lr);
                end
                tests_run++;
                if (ar_addr_log[iai] !== ia || ar_id_log[iai] !== 4'd0 || rd !== r_data_log[iri]) begin
                    tests_failed++;
                    $display("FAIL rnd%0d_inst_payload: got addr=%h id=%h rd=%h expected %h 0 %h",
                             t, ar_addr_log[iai], ar_id_log[iai], rd, ia, r_data_log[iri]);
                end
            end
        end
    endtask

    task automatic test_protocol();
        tests_run++;
        if (proto_err !== 0) begin tests_failed++; $display("FAIL axi_protocol: got %0d violations expected 0", proto_err); end
        tests_run++;
        if (dok_err !== 0) begin tests_failed++; $display("FAIL dok_pulse: got %0d violations expected 0", dok_err); end
    endtask

    initial begin
        resetn = 1'b1;
        inst_cache_req = 1'b0; inst_cache_addr = '0;
        data_cache_req = 1'b0; data_cache_wr = 1'b0; data_cache_wstrb = '0;
        data_cache_addr = '0; data_cache_wdata = '0;
        #1 resetn = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        test_inst_read();
        test_simultaneous();
        test_write("wr_aw_first", 0, 3, 1);
        test_write("wr_w_first", 2, 0, 2);
        test_backpressure();
        test_reset_midop();
        test_random();
        repeat (4) @(negedge clk);
        test_protocol();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
